// File: rtl/exc_pkg.sv
// Shared encodings for the exception sequencer and the main control unit:
// cause codes, sequencer state encoding and default handler vector addresses.
package exc_pkg;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OPC  = 2'b01;
  localparam logic [1:0] CAUSE_OVF  = 2'b10;
  localparam logic [1:0] CAUSE_DIV  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SAVE = 3'd1,
    WAIT = 3'd2,
    LOAD = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int unsigned VEC_OPCODE_DEF   = 253;
  localparam int unsigned VEC_OVERFLOW_DEF = 254;
  localparam int unsigned VEC_DIVZERO_DEF  = 255;

  // Divide-by-zero outranks overflow, which outranks invalid opcode.
  function automatic logic [1:0] pick_cause(input logic div, input logic ovf, input logic opc);
    if (div)      return CAUSE_DIV;
    else if (ovf) return CAUSE_OVF;
    else if (opc) return CAUSE_OPC;
    else          return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// Request/takeover bundle between the main control unit (master) and the
// exception sequencer (slave).
interface exc_sequencer_if;
  logic        opcode_ex;
  logic        overflow_ex;
  logic        divzero_ex;
  logic [31:0] pc_in;
  logic [31:0] mem_data_in;
  logic        busy;
  logic        done;
  logic [1:0]  cause;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] epc_out;
  logic        epc_write;
  logic [31:0] pc_out;
  logic        pc_write;

  modport master (
    output opcode_ex, overflow_ex, divzero_ex, pc_in, mem_data_in,
    input  busy, done, cause, mem_addr, mem_read, epc_out, epc_write, pc_out, pc_write
  );

  modport slave (
    input  opcode_ex, overflow_ex, divzero_ex, pc_in, mem_data_in,
    output busy, done, cause, mem_addr, mem_read, epc_out, epc_write, pc_out, pc_write
  );
endinterface

// File: rtl/exc_sequencer.sv
// Multicycle exception sequencer: saves EPC, fetches the handler vector byte,
// loads PC and pulses done. All outputs are registered alongside the state.
module exc_sequencer
  import exc_pkg::*;
#(
  parameter int unsigned VEC_OPCODE   = VEC_OPCODE_DEF,
  parameter int unsigned VEC_OVERFLOW = VEC_OVERFLOW_DEF,
  parameter int unsigned VEC_DIVZERO  = VEC_DIVZERO_DEF,
  parameter int unsigned MEM_LAT      = 2
) (
  input  logic            clk,
  input  logic            reset,
  exc_sequencer_if.slave  bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  function automatic logic [31:0] vec_addr(input logic [1:0] c);
    unique case (c)
      CAUSE_OPC: return 32'(VEC_OPCODE);
      CAUSE_OVF: return 32'(VEC_OVERFLOW);
      CAUSE_DIV: return 32'(VEC_DIVZERO);
      default:   return 32'd0;
    endcase
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cause_q;
  logic             busy_q;
  logic             done_q;
  logic [31:0]      mem_addr_q;
  logic             mem_read_q;
  logic [31:0]      epc_out_q;
  logic             epc_write_q;
  logic [31:0]      pc_out_q;
  logic             pc_write_q;

  logic       any_req;
  logic [1:0] new_cause;
  logic       unused_hi;

  assign any_req   = bus.opcode_ex | bus.overflow_ex | bus.divzero_ex;
  assign new_cause = pick_cause(bus.divzero_ex, bus.overflow_ex, bus.opcode_ex);
  // The handler vector is a byte; the upper memory bits carry nothing useful.
  assign unused_hi = ^bus.mem_data_in[31:8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cause_q     <= CAUSE_NONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      epc_out_q   <= '0;
      epc_write_q <= 1'b0;
      pc_out_q    <= '0;
      pc_write_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state       <= SAVE;
            cause_q     <= new_cause;
            busy_q      <= 1'b1;
            epc_write_q <= 1'b1;
            epc_out_q   <= bus.pc_in - 32'd4;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= vec_addr(new_cause);
          end
        end
        SAVE: begin
          state       <= WAIT;
          cnt         <= CNT_INIT;
          epc_write_q <= 1'b0;
          epc_out_q   <= '0;
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= LOAD;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            pc_write_q <= 1'b1;
            pc_out_q   <= {24'b0, bus.mem_data_in[7:0]};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOAD: begin
          state      <= DONE;
          pc_write_q <= 1'b0;
          pc_out_q   <= '0;
          done_q     <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          mem_read_q  <= 1'b0;
          mem_addr_q  <= '0;
          epc_write_q <= 1'b0;
          epc_out_q   <= '0;
          pc_write_q  <= 1'b0;
          pc_out_q    <= '0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cause     = cause_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.epc_out   = epc_out_q;
  assign bus.epc_write = epc_write_q;
  assign bus.pc_out    = pc_out_q;
  assign bus.pc_write  = pc_write_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: directed scenarios plus randomized
// exceptions compared against a cycle-count reference model.
module tb_exc_sequencer;
  import exc_pkg::*;

  localparam int MEM_LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  exc_sequencer_if bus ();

  exc_sequencer #(
    .VEC_OPCODE  (253),
    .VEC_OVERFLOW(254),
    .VEC_DIVZERO (255),
    .MEM_LAT     (MEM_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Observations of one exception sequence, cycle 1 = first cycle after the accepting edge.
  int          o_busy_n, o_epc_n, o_epc_cyc, o_read_n, o_read_cyc, o_pcw_n, o_pcw_cyc, o_done_n, o_done_cyc;
  logic [31:0] o_epc, o_addr, o_pc;
  logic        o_addr_stable;
  logic [1:0]  o_cause;

  function automatic logic [1:0] model_cause(input logic opc, input logic ovf, input logic div);
    if (div) return 2'b11;
    if (ovf) return 2'b10;
    if (opc) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_vec(input logic [1:0] c);
    case (c)
      2'b01:   return 32'd253;
      2'b10:   return 32'd254;
      2'b11:   return 32'd255;
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_inputs;
    bus.opcode_ex   = 1'b0;
    bus.overflow_ex = 1'b0;
    bus.divzero_ex  = 1'b0;
    bus.pc_in       = '0;
    bus.mem_data_in = '0;
  endtask

  // Raise the requests for one cycle, then observe 12 cycles; inject_cyc > 0
  // raises opcode_ex for the edge that closes that cycle.
  task automatic run_exc(input logic opc, input logic ovf, input logic div,
                         input logic [31:0] pc, input logic [31:0] data, input int inject_cyc);
    @(posedge clk); #1;
    bus.opcode_ex = opc; bus.overflow_ex = ovf; bus.divzero_ex = div;
    bus.pc_in = pc; bus.mem_data_in = data;
    @(posedge clk); #1;
    bus.opcode_ex = 1'b0; bus.overflow_ex = 1'b0; bus.divzero_ex = 1'b0;
    o_busy_n = 0; o_epc_n = 0; o_epc_cyc = 0; o_read_n = 0; o_read_cyc = 0;
    o_pcw_n = 0; o_pcw_cyc = 0; o_done_n = 0; o_done_cyc = 0;
    o_epc = '0; o_addr = '0; o_pc = '0; o_addr_stable = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.busy) o_busy_n++;
      if (bus.epc_write) begin o_epc_n++; o_epc_cyc = c; o_epc = bus.epc_out; end
      if (bus.mem_read) begin
        if (o_read_n == 0) begin o_read_cyc = c; o_addr = bus.mem_addr; end
        else if (bus.mem_addr !== o_addr) o_addr_stable = 1'b0;
        o_read_n++;
      end
      if (bus.pc_write) begin o_pcw_n++; o_pcw_cyc = c; o_pc = bus.pc_out; end
      if (bus.done) begin o_done_n++; o_done_cyc = c; end
      if (c == inject_cyc) bus.opcode_ex = 1'b1;
      @(posedge clk); #1;
      bus.opcode_ex = 1'b0;
    end
    o_cause = bus.cause;
  endtask

  task automatic test_reset;
    clear_inputs();
    #2 reset = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++;
      $display("FAIL reset_busy_done: busy=%b done=%b required 0 0", bus.busy, bus.done); end
    vectors++; if (bus.cause !== 2'b00) begin miscompares++;
      $display("FAIL reset_cause: got %b required 00", bus.cause); end
    vectors++; if ({bus.mem_read, bus.epc_write, bus.pc_write} !== 3'b000 || bus.mem_addr !== 32'd0
                   || bus.epc_out !== 32'd0 || bus.pc_out !== 32'd0) begin miscompares++;
      $display("FAIL reset_outputs: rd=%b ew=%b pw=%b addr=%h epc=%h pc=%h required all 0",
               bus.mem_read, bus.epc_write, bus.pc_write, bus.mem_addr, bus.epc_out, bus.pc_out); end
    bus.divzero_ex = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++;
      $display("FAIL reset_held_busy: got %b required 0", bus.busy); end
    bus.divzero_ex = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_overflow;
    run_exc(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_00A0, 0);
    vectors++; if (o_epc_n !== 1 || o_epc_cyc !== 1 || o_epc !== 32'h0000_003C) begin miscompares++;
      $display("FAIL ovf_epc: n=%0d cyc=%0d val=%h required 1 1 0000003c", o_epc_n, o_epc_cyc, o_epc); end
    vectors++; if (o_addr !== 32'd254 || !o_addr_stable) begin miscompares++;
      $display("FAIL ovf_addr: got %0d stable=%b required 254 stable", o_addr, o_addr_stable); end
    vectors++; if (o_read_n !== MEM_LAT + 1 || o_read_cyc !== 1) begin miscompares++;
      $display("FAIL ovf_read: cycles=%0d first=%0d required %0d 1", o_read_n, o_read_cyc, MEM_LAT + 1); end
    vectors++; if (o_pcw_n !== 1 || o_pcw_cyc !== MEM_LAT + 2 || o_pc !== 32'h0000_00A0) begin miscompares++;
      $display("FAIL ovf_pc: n=%0d cyc=%0d val=%h required 1 %0d 000000a0", o_pcw_n, o_pcw_cyc, o_pc, MEM_LAT + 2); end
    vectors++; if (o_done_n !== 1 || o_done_cyc !== 5) begin miscompares++;
      $display("FAIL ovf_done: n=%0d cyc=%0d required 1 5", o_done_n, o_done_cyc); end
    vectors++; if (o_busy_n !== MEM_LAT + 3 || o_cause !== 2'b10) begin miscompares++;
      $display("FAIL ovf_busy_cause: busy=%0d cause=%b required %0d 10", o_busy_n, o_cause, MEM_LAT + 3); end
  endtask

  task automatic test_priority;
    run_exc(1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0033, 0);
    vectors++; if (o_cause !== 2'b11 || o_addr !== 32'd255) begin miscompares++;
      $display("FAIL prio_div_ovf: cause=%b addr=%0d required 11 255", o_cause, o_addr); end
    run_exc(1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_0044, 0);
    vectors++; if (o_cause !== 2'b11 || o_addr !== 32'd255 || o_done_n !== 1) begin miscompares++;
      $display("FAIL prio_div_opc: cause=%b addr=%0d dones=%0d required 11 255 1", o_cause, o_addr, o_done_n); end
  endtask

  task automatic test_ignore_busy;
    run_exc(1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0011, 2);
    vectors++; if (o_cause !== 2'b10 || o_done_n !== 1 || o_busy_n !== MEM_LAT + 3) begin miscompares++;
      $display("FAIL ignore_busy: cause=%b dones=%0d busy=%0d required 10 1 %0d", o_cause, o_done_n, o_busy_n, MEM_LAT + 3); end
    vectors++; if (o_epc_n !== 1 || o_pcw_n !== 1) begin miscompares++;
      $display("FAIL ignore_busy_writes: epc_writes=%0d pc_writes=%0d required 1 1", o_epc_n, o_pcw_n); end
  endtask

  task automatic test_async_reset;
    int pcw_seen = 0;
    int busy_seen = 0;
    @(posedge clk); #1;
    bus.overflow_ex = 1'b1; bus.pc_in = 32'h0000_0100; bus.mem_data_in = 32'h0000_0055;
    @(posedge clk); #1;
    bus.overflow_ex = 1'b0;
    @(posedge clk); #1;
    vectors++; if (bus.mem_read !== 1'b1 || bus.busy !== 1'b1) begin miscompares++;
      $display("FAIL areset_pre: rd=%b busy=%b required 1 1", bus.mem_read, bus.busy); end
    #2 reset = 1'b0;
    #1;
    vectors++; if ({bus.busy, bus.done, bus.mem_read, bus.epc_write, bus.pc_write} !== 5'b0
                   || bus.cause !== 2'b00 || bus.mem_addr !== 32'd0) begin miscompares++;
      $display("FAIL areset_now: busy=%b done=%b rd=%b ew=%b pw=%b cause=%b addr=%h required all 0",
               bus.busy, bus.done, bus.mem_read, bus.epc_write, bus.pc_write, bus.cause, bus.mem_addr); end
    @(negedge clk); #1 reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.pc_write) pcw_seen++;
      if (bus.busy) busy_seen++;
    end
    vectors++; if (pcw_seen !== 0 || busy_seen !== 0) begin miscompares++;
      $display("FAIL areset_after: pc_writes=%0d busy_cycles=%0d required 0 0", pcw_seen, busy_seen); end
  endtask

  task automatic test_wrap;
    run_exc(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FF12, 0);
    vectors++; if (o_epc !== 32'hFFFF_FFFC) begin miscompares++;
      $display("FAIL wrap_epc: got %h required fffffffc", o_epc); end
    vectors++; if (o_pc !== 32'h0000_0012 || o_cause !== 2'b01 || o_addr !== 32'd253) begin miscompares++;
      $display("FAIL wrap_pc: pc=%h cause=%b addr=%0d required 00000012 01 253", o_pc, o_cause, o_addr); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  req;
      logic [31:0] pc, data;
      logic [1:0]  ec;
      req  = 3'($urandom_range(1, 7));
      pc   = $urandom;
      data = $urandom;
      ec   = model_cause(req[0], req[1], req[2]);
      run_exc(req[0], req[1], req[2], pc, data, 0);
      vectors++; if (o_cause !== ec || o_addr !== model_vec(ec)) begin miscompares++;
        $display("FAIL rand_cause[%0d]: cause=%b addr=%0d required %b %0d", i, o_cause, o_addr, ec, model_vec(ec)); end
      vectors++; if (o_epc !== pc - 32'd4 || o_pc !== (data & 32'h0000_00FF)) begin miscompares++;
        $display("FAIL rand_values[%0d]: epc=%h pc=%h required %h %h", i, o_epc, o_pc, pc - 32'd4, data & 32'h0000_00FF); end
      vectors++; if (o_done_cyc !== MEM_LAT + 3 || o_read_n !== MEM_LAT + 1 || o_done_n !== 1) begin miscompares++;
        $display("FAIL rand_timing[%0d]: done_cyc=%0d reads=%0d dones=%0d required %0d %0d 1",
                 i, o_done_cyc, o_read_n, o_done_n, MEM_LAT + 3, MEM_LAT + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_priority();
    test_ignore_busy();
    test_async_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
